// File: rtl/vga_timing_rx.sv
// VGA pin-level receiver: recovers pixel coordinates from hsync/vsync/de,
// measures line/frame timing and locks when the timing matches H_RES x V_RES.
module vga_timing_rx #(
  parameter int CORDW       = 16,
  parameter int H_RES       = 640,
  parameter int V_RES       = 480,
  parameter bit HSYNC_POL   = 1'b0,
  parameter bit VSYNC_POL   = 1'b0,
  parameter int LOCK_FRAMES = 2
) (
  input  logic             clk_pix,
  input  logic             rst_pix,
  input  logic             hsync,
  input  logic             vsync,
  input  logic             de,
  input  logic [3:0]       vga_r,
  input  logic [3:0]       vga_g,
  input  logic [3:0]       vga_b,
  output logic             pix_valid,
  output logic [CORDW-1:0] sx,
  output logic [CORDW-1:0] sy,
  output logic [11:0]      pix_rgb,
  output logic             line_start,
  output logic             frame_start,
  output logic             locked,
  output logic [CORDW-1:0] h_active_meas,
  output logic [CORDW-1:0] h_total_meas,
  output logic [CORDW-1:0] v_active_meas,
  output logic [7:0]       err_cnt
);

  localparam logic [CORDW-1:0] H_RES_W = CORDW'(H_RES);
  localparam logic [CORDW-1:0] V_RES_W = CORDW'(V_RES);
  localparam logic [3:0]       LOCK_N  = 4'(LOCK_FRAMES);

  typedef enum logic [1:0] {SEARCH, CHECK, LOCKED} state_t;

  state_t           state;
  logic [3:0]       good_cnt;
  logic             hs_q, vs_q, de_q, hs_d, vs_d, de_d;
  logic [11:0]      rgb_q;
  logic [CORDW-1:0] x_cnt, y_cnt, h_per;
  logic             line_bad;

  logic             hs_lead, vs_lead, de_rise, de_fall;
  logic [CORDW-1:0] y_fold;
  logic             bad_fold, frame_ok;

  function automatic logic [CORDW-1:0] sat_inc(input logic [CORDW-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  assign hs_lead = (hs_q == HSYNC_POL) && (hs_d != HSYNC_POL);
  assign vs_lead = (vs_q == VSYNC_POL) && (vs_d != VSYNC_POL);
  assign de_rise = de_q && !de_d;
  assign de_fall = !de_q && de_d;

  // A line ending in the same cycle as the vsync edge belongs to the closing frame.
  always_comb begin
    y_fold   = y_cnt;
    bad_fold = line_bad;
    if (de_fall) begin
      y_fold   = sat_inc(y_cnt);
      bad_fold = line_bad || (x_cnt != H_RES_W);
    end
    frame_ok = !bad_fold && (y_fold == V_RES_W) && !de_q;
  end

  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      hs_q          <= ~HSYNC_POL;
      hs_d          <= ~HSYNC_POL;
      vs_q          <= ~VSYNC_POL;
      vs_d          <= ~VSYNC_POL;
      de_q          <= 1'b0;
      de_d          <= 1'b0;
      rgb_q         <= '0;
      x_cnt         <= '0;
      y_cnt         <= '0;
      h_per         <= '0;
      line_bad      <= 1'b0;
      state         <= SEARCH;
      good_cnt      <= '0;
      pix_valid     <= 1'b0;
      sx            <= '0;
      sy            <= '0;
      pix_rgb       <= '0;
      line_start    <= 1'b0;
      frame_start   <= 1'b0;
      locked        <= 1'b0;
      h_active_meas <= '0;
      h_total_meas  <= '0;
      v_active_meas <= '0;
      err_cnt       <= '0;
    end else begin
      hs_q  <= hsync;
      vs_q  <= vsync;
      de_q  <= de;
      rgb_q <= {vga_r, vga_g, vga_b};
      hs_d  <= hs_q;
      vs_d  <= vs_q;
      de_d  <= de_q;

      pix_valid   <= de_q;
      pix_rgb     <= de_q ? rgb_q : 12'h000;
      line_start  <= de_rise;
      frame_start <= vs_lead;

      h_per <= sat_inc(h_per);
      if (hs_lead) begin
        h_total_meas <= sat_inc(h_per);
        h_per        <= '0;
      end

      if (de_q) begin
        sx    <= x_cnt;
        sy    <= y_cnt;
        x_cnt <= sat_inc(x_cnt);
      end

      if (de_fall) begin
        h_active_meas <= x_cnt;
        line_bad      <= bad_fold;
        y_cnt         <= y_fold;
        x_cnt         <= '0;
      end

      if (vs_lead) begin
        v_active_meas <= y_fold;
        y_cnt         <= '0;
        line_bad      <= 1'b0;
        case (state)
          SEARCH: begin
            state    <= CHECK;
            good_cnt <= '0;
          end
          CHECK: begin
            if (frame_ok) begin
              good_cnt <= good_cnt + 4'd1;
              if (good_cnt + 4'd1 == LOCK_N) begin
                state  <= LOCKED;
                locked <= 1'b1;
              end
            end else begin
              good_cnt <= '0;
            end
          end
          LOCKED: begin
            if (!frame_ok) begin
              state    <= CHECK;
              locked   <= 1'b0;
              good_cnt <= '0;
              err_cnt  <= (err_cnt == 8'hFF) ? err_cnt : err_cnt + 8'd1;
            end
          end
          default: begin
            state  <= SEARCH;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_rx.sv
// Bench for vga_timing_rx on a reduced 8x4 mode (11x7 totals) with random
// pixel data and randomly corrupted frames, checked against a frame-level model.
module tb_vga_timing_rx;
  localparam int CORDW       = 16;
  localparam int H_RES       = 8;
  localparam int V_RES       = 4;
  localparam int LOCK_FRAMES = 2;
  localparam int HT          = 11;
  localparam int VT          = 7;
  localparam int HS_COL      = 9;

  logic             clk_pix = 1'b0;
  logic             rst_pix, hsync, vsync, de;
  logic [3:0]       vga_r, vga_g, vga_b;
  logic             pix_valid, line_start, frame_start, locked;
  logic [CORDW-1:0] sx, sy, h_active_meas, h_total_meas, v_active_meas;
  logic [11:0]      pix_rgb;
  logic [7:0]       err_cnt;

  vga_timing_rx #(
    .CORDW(CORDW), .H_RES(H_RES), .V_RES(V_RES),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .LOCK_FRAMES(LOCK_FRAMES)
  ) dut (
    .clk_pix(clk_pix), .rst_pix(rst_pix), .hsync(hsync), .vsync(vsync), .de(de),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .pix_valid(pix_valid), .sx(sx), .sy(sy), .pix_rgb(pix_rgb),
    .line_start(line_start), .frame_start(frame_start), .locked(locked),
    .h_active_meas(h_active_meas), .h_total_meas(h_total_meas),
    .v_active_meas(v_active_meas), .err_cnt(err_cnt)
  );

  always #5 clk_pix = ~clk_pix;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct {bit v; bit ls; int x; int y; logic [11:0] rgb;} pix_t;
  typedef struct {int vact; bit lk; int err; int hact; bit ht_ok;} frm_t;

  pix_t rec[8];
  frm_t fq[$];
  int   edge_n = 0;

  // Reference model state, advanced once per driven input cycle.
  int mx, my, last_len, streak, err_m, hs_seen;
  bit mbad, seen, lockd, prev_de, prev_vs, prev_hs;

  always @(posedge clk_pix) edge_n++;

  task automatic model_reset();
    mx = 0; my = 0; last_len = 0; streak = 0; err_m = 0; hs_seen = 0;
    mbad = 0; seen = 0; lockd = 0; prev_de = 0; prev_vs = 0; prev_hs = 0;
  endtask

  task automatic drive(input bit r, input bit d, input bit h, input bit v, input bit cz);
    logic [11:0] c;
    bit fall, lead, ok;
    pix_t p;
    @(posedge clk_pix);
    #1;
    if (cz) begin
      chk("rst_pix_valid", pix_valid, 0);
      chk("rst_sx", sx, 0);
      chk("rst_sy", sy, 0);
      chk("rst_rgb", pix_rgb, 0);
      chk("rst_line_start", line_start, 0);
      chk("rst_frame_start", frame_start, 0);
      chk("rst_locked", locked, 0);
      chk("rst_h_active", h_active_meas, 0);
      chk("rst_h_total", h_total_meas, 0);
      chk("rst_v_active", v_active_meas, 0);
      chk("rst_err_cnt", err_cnt, 0);
    end
    c = 12'($urandom);
    rst_pix = r;
    de      = d;
    hsync   = ~h;
    vsync   = ~v;
    {vga_r, vga_g, vga_b} = c;
    p.v = 0; p.ls = 0; p.x = 0; p.y = 0; p.rgb = 12'h000;
    if (r) begin
      model_reset();
      rec[edge_n % 8] = p;
      rec[(edge_n + 7) % 8].v  = 0;
      rec[(edge_n + 7) % 8].ls = 0;
      return;
    end
    if (d) begin
      p.v = 1; p.x = mx; p.y = my; p.ls = (mx == 0); p.rgb = c;
      mx++;
    end
    if (h && !prev_hs) hs_seen++;
    fall = prev_de && !d;
    lead = v && !prev_vs;
    if (fall) begin
      last_len = mx;
      if (mx != H_RES) mbad = 1;
      my++;
      mx = 0;
    end
    if (lead) begin
      ok = !mbad && (my == V_RES) && !d;
      if (!seen) begin
        seen = 1; streak = 0;
      end else if (lockd) begin
        if (!ok) begin
          lockd = 0; streak = 0;
          err_m = (err_m < 255) ? err_m + 1 : 255;
        end
      end else if (ok) begin
        streak++;
        if (streak >= LOCK_FRAMES) lockd = 1;
      end else begin
        streak = 0;
      end
      fq.push_back('{vact: my, lk: lockd, err: err_m, hact: last_len, ht_ok: (hs_seen >= 2)});
      my = 0;
      mbad = 0;
    end
    prev_de = d; prev_vs = v; prev_hs = h;
    rec[edge_n % 8] = p;
  endtask

  // kind: 0 clean, 1 short line, 2 long line, 3 last line dropped,
  // 4 de fall coincident with vsync edge, 5 de run open at vsync, 6 reset mid-frame
  task automatic frame(input int kind);
    int lens[V_RES];
    int vs_start, line, col;
    bit d, r, cz;
    for (int i = 0; i < V_RES; i++) lens[i] = H_RES;
    vs_start = 5 * HT;
    case (kind)
      1: lens[$urandom_range(0, V_RES - 1)] = H_RES - 1;
      2: lens[$urandom_range(0, V_RES - 1)] = H_RES + 1;
      3: lens[V_RES - 1] = 0;
      4: vs_start = (V_RES - 1) * HT + H_RES;
      5: vs_start = (V_RES - 1) * HT + 4;
      default: ;
    endcase
    for (int c = 0; c < HT * VT; c++) begin
      line = c / HT;
      col  = c % HT;
      d  = (line < V_RES) && (col < lens[line]);
      r  = (kind == 6) && (c == HT + 3);
      cz = (kind == 6) && (c == HT + 4);
      drive(r, d, col == HS_COL, (c >= vs_start) && (c < vs_start + HT), cz);
    end
  endtask

  always @(negedge clk_pix) begin
    pix_t r;
    frm_t f;
    if (edge_n >= 2) begin
      r = rec[(edge_n - 2) % 8];
      chk("pix_valid", pix_valid, r.v);
      if (r.v) begin
        chk("sx", sx, r.x);
        chk("sy", sy, r.y);
        chk("pix_rgb", pix_rgb, r.rgb);
        chk("line_start", line_start, r.ls);
      end else begin
        chk("pix_rgb_blank", pix_rgb, 0);
        chk("line_start_blank", line_start, 0);
      end
      if (frame_start) begin
        if (fq.size() == 0) begin
          chk("frame_start_spurious", frame_start, 0);
        end else begin
          f = fq.pop_front();
          chk("v_active_meas", v_active_meas, f.vact);
          chk("locked", locked, f.lk);
          chk("err_cnt", err_cnt, f.err);
          chk("h_active_meas", h_active_meas, f.hact);
          if (f.ht_ok) chk("h_total_meas", h_total_meas, HT);
        end
      end
    end
  end

  initial begin
    int k;
    rst_pix = 1'b1; de = 1'b0; hsync = 1'b1; vsync = 1'b1;
    vga_r = '0; vga_g = '0; vga_b = '0;
    for (int i = 0; i < 8; i++) begin
      rec[i].v = 0; rec[i].ls = 0; rec[i].x = 0; rec[i].y = 0; rec[i].rgb = 12'h000;
    end
    model_reset();
    repeat (3) drive(1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1);

    frame(0);
    frame(0);
    chk("no_lock_before_third_edge", locked, 0);
    frame(0);
    chk("lock_after_third_edge", locked, 1);
    chk("h_total_clean", h_total_meas, HT);
    chk("v_active_clean", v_active_meas, V_RES);

    frame(1);
    chk("lock_lost_short_line", locked, 0);
    chk("err_after_short_line", err_cnt, 1);
    frame(0);
    chk("still_checking", locked, 0);
    frame(0);
    chk("relock_after_two", locked, 1);

    frame(4);
    chk("fold_lock_kept", locked, 1);
    chk("fold_v_active", v_active_meas, V_RES);

    repeat (40) begin
      k = int'($urandom_range(0, 9));
      frame((k < 5) ? 0 : k - 4);
    end

    repeat (3) frame(0);
    chk("locked_before_reset", locked, 1);
    frame(6);
    frame(0);
    chk("no_relock_second_edge", locked, 0);
    frame(0);
    chk("relock_third_edge", locked, 1);

    repeat (300) begin
      frame(3);
      frame(0);
      frame(0);
    end
    chk("err_cnt_saturated", err_cnt, 255);
    chk("drop_v_active", v_active_meas, V_RES);

    repeat (5) drive(0, 0, 0, 0, 0);
    chk("frames_all_seen", fq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
